countdown_ctrl: RTL and testbench

Synchronous controller that sequences the 6-bit countdown datapath from a single system clock. It replaces edge-driven decrementing with a prescaled tick, adds start/pause control, load of a programmable start value and end-of-count signalling. It sits between the board buttons and the two existing `sevenseg` decoders that drive the count display.

---
 rtl/countdown_pkg.sv | 16 +
 rtl/edge_detect.sv | 22 ++
 rtl/sevenseg.sv | 31 +++
 rtl/countdown_ctrl.sv | 132 +++++++++++++
 tb/tb_countdown_ctrl.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/countdown_pkg.sv
// Shared widths, reset value and state encoding for the countdown controller.
package countdown_pkg;

  localparam int unsigned COUNT_W = 6;
  localparam int unsigned SEG_W   = 7;

  localparam logic [COUNT_W-1:0] COUNT_RESET = 6'h3F;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } cd_state_t;

endpackage

// File: rtl/edge_detect.sv
// Synchronous rising-edge detector; history resets high so a level held
// through reset is not seen as an edge.
module edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic in_i,
  output logic rise_o
);

  logic in_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      in_q <= 1'b1;
    end else begin
      in_q <= in_i;
    end
  end

  assign rise_o = in_i & ~in_q;

endmodule

// File: rtl/sevenseg.sv
// Hex digit to seven-segment pattern, active-high segments ordered {g,f,e,d,c,b,a}.
module sevenseg
  import countdown_pkg::*;
(
  input  logic [3:0]       hex_i,
  output logic [SEG_W-1:0] seg_o
);

  always_comb begin
    seg_o = '0;
    case (hex_i)
      4'h0:    seg_o = 7'h3F;
      4'h1:    seg_o = 7'h06;
      4'h2:    seg_o = 7'h5B;
      4'h3:    seg_o = 7'h4F;
      4'h4:    seg_o = 7'h66;
      4'h5:    seg_o = 7'h6D;
      4'h6:    seg_o = 7'h7D;
      4'h7:    seg_o = 7'h07;
      4'h8:    seg_o = 7'h7F;
      4'h9:    seg_o = 7'h6F;
      4'hA:    seg_o = 7'h77;
      4'hB:    seg_o = 7'h7C;
      4'hC:    seg_o = 7'h39;
      4'hD:    seg_o = 7'h5E;
      4'hE:    seg_o = 7'h79;
      default: seg_o = 7'h71;
    endcase
  end

endmodule

// File: rtl/countdown_ctrl.sv
// Prescaled countdown sequencer with start/pause buttons, programmable load
// and end-of-count alarm, driving two seven-segment digits.
module countdown_ctrl
  import countdown_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               pause,
  input  logic [COUNT_W-1:0] load_val,
  output logic [COUNT_W-1:0] count,
  output logic               running,
  output logic               done,
  output logic               alarm,
  output logic [SEG_W-1:0]   d0,
  output logic [SEG_W-1:0]   d1
);

  localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  cd_state_t          state_q;
  logic [COUNT_W-1:0] count_q;
  logic [PRE_W-1:0]   pre_q;
  logic               running_q;
  logic               done_q;
  logic               alarm_q;

  logic start_rise;
  logic pause_rise;
  logic tick_c;
  logic load_c;

  edge_detect u_start_edge (
    .clk    (clk),
    .reset  (reset),
    .in_i   (start),
    .rise_o (start_rise)
  );

  edge_detect u_pause_edge (
    .clk    (clk),
    .reset  (reset),
    .in_i   (pause),
    .rise_o (pause_rise)
  );

  assign tick_c = (state_q == RUN) && (pre_q == PRE_LAST);
  // start reloads from every state except RUN, and beats a coincident pause
  assign load_c = start_rise && (state_q != RUN);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      count_q   <= COUNT_RESET;
      pre_q     <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      alarm_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (load_c) begin
        count_q <= load_val;
        pre_q   <= '0;
        if (load_val == '0) begin
          state_q   <= DONE;
          running_q <= 1'b0;
          done_q    <= 1'b1;
          alarm_q   <= 1'b1;
        end else begin
          state_q   <= RUN;
          running_q <= 1'b1;
          alarm_q   <= 1'b0;
        end
      end else begin
        case (state_q)
          RUN: begin
            if (tick_c) begin
              pre_q <= '0;
              // reaching zero wins over a coincident pause edge
              if (count_q <= COUNT_W'(1)) begin
                count_q   <= '0;
                state_q   <= DONE;
                running_q <= 1'b0;
                done_q    <= 1'b1;
                alarm_q   <= 1'b1;
              end else begin
                count_q <= count_q - COUNT_W'(1);
                if (pause_rise) begin
                  state_q   <= PAUSE;
                  running_q <= 1'b0;
                end
              end
            end else begin
              pre_q <= pre_q + PRE_W'(1);
              if (pause_rise) begin
                state_q   <= PAUSE;
                running_q <= 1'b0;
              end
            end
          end
          PAUSE: begin
            if (pause_rise) begin
              state_q   <= RUN;
              running_q <= 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign count   = count_q;
  assign running = running_q;
  assign done    = done_q;
  assign alarm   = alarm_q;

  sevenseg u_seg_lo (
    .hex_i (count_q[3:0]),
    .seg_o (d0)
  );

  sevenseg u_seg_hi (
    .hex_i ({2'b00, count_q[5:4]}),
    .seg_o (d1)
  );

endmodule

// File: tb/tb_countdown_ctrl.sv
// Directed and random stimulus for countdown_ctrl, checked against a
// cycle-level behavioural model of the countdown rules.
module tb_countdown_ctrl;

  localparam int unsigned TICK_DIV = 4;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  localparam logic [6:0] SEG_TBL [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic       clk;
  logic       reset;
  logic       start;
  logic       pause;
  logic [5:0] load_val;
  logic [5:0] count;
  logic       running;
  logic       done;
  logic       alarm;
  logic [6:0] d0;
  logic [6:0] d1;

  int n_vec;
  int n_err;

  // behavioural model: mode, count, RUN cycles since last tick/load
  int m_mode;
  int m_count;
  int m_elapsed;
  bit m_done;
  bit m_sq;
  bit m_pq;

  countdown_ctrl #(.TICK_DIV(TICK_DIV)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .pause    (pause),
    .load_val (load_val),
    .count    (count),
    .running  (running),
    .done     (done),
    .alarm    (alarm),
    .d0       (d0),
    .d1       (d1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_update();
    bit se;
    bit pe;
    if (reset) begin
      m_mode    = M_IDLE;
      m_count   = 63;
      m_elapsed = 0;
      m_done    = 1'b0;
      m_sq      = 1'b1;
      m_pq      = 1'b1;
      return;
    end
    se     = start && !m_sq;
    pe     = pause && !m_pq;
    m_sq   = start;
    m_pq   = pause;
    m_done = 1'b0;
    if (se && m_mode != M_RUN) begin
      m_count   = int'(load_val);
      m_elapsed = 0;
      if (m_count == 0) begin
        m_mode = M_DONE;
        m_done = 1'b1;
      end else begin
        m_mode = M_RUN;
      end
    end else if (m_mode == M_RUN) begin
      m_elapsed++;
      if (m_elapsed == TICK_DIV) begin
        m_elapsed = 0;
        m_count--;
        if (m_count == 0) begin
          m_mode = M_DONE;
          m_done = 1'b1;
        end else if (pe) begin
          m_mode = M_PAUSE;
        end
      end else if (pe) begin
        m_mode = M_PAUSE;
      end
    end else if (m_mode == M_PAUSE && pe) begin
      m_mode = M_RUN;
    end
  endtask

  task automatic check_all();
    chk("count",   32'(count),   32'(m_count));
    chk("running", 32'(running), 32'(m_mode == M_RUN));
    chk("done",    32'(done),    32'(m_done));
    chk("alarm",   32'(alarm),   32'(m_mode == M_DONE));
    chk("d0",      32'(d0),      32'(SEG_TBL[m_count % 16]));
    chk("d1",      32'(d1),      32'(SEG_TBL[m_count / 16]));
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      model_update();
      check_all();
    end
  endtask

  initial begin
    n_vec    = 0;
    n_err    = 0;
    reset    = 1'b1;
    start    = 1'b0;
    pause    = 1'b0;
    load_val = '0;

    // reset values
    step(2);
    chk("rst_count", 32'(count), 32'd63);
    chk("rst_d0", 32'(d0), 32'h71);
    chk("rst_d1", 32'(d1), 32'h4F);
    chk("rst_running", 32'(running), 32'd0);
    chk("rst_alarm", 32'(alarm), 32'd0);

    // start held through reset is not an edge
    start = 1'b1;
    step(1);
    reset = 1'b0;
    step(2);
    chk("held_start_idle", 32'(running), 32'd0);
    chk("held_start_count", 32'(count), 32'd63);
    start = 1'b0;
    step(1);

    // full countdown from 3
    load_val = 6'd3;
    start    = 1'b1;
    step(1);
    chk("cd_running", 32'(running), 32'd1);
    chk("cd_load", 32'(count), 32'd3);
    start = 1'b0;
    step(3);
    chk("cd_hold3", 32'(count), 32'd3);
    step(1);
    chk("cd_plus4", 32'(count), 32'd2);
    step(4);
    chk("cd_plus8", 32'(count), 32'd1);
    step(4);
    chk("cd_plus12", 32'(count), 32'd0);
    chk("cd_done", 32'(done), 32'd1);
    step(1);
    chk("cd_done_pulse", 32'(done), 32'd0);
    chk("cd_alarm", 32'(alarm), 32'd1);

    // pause after two RUN cycles, hold ten, resume
    load_val = 6'd5;
    start    = 1'b1;
    step(1);
    start = 1'b0;
    step(1);
    pause = 1'b1;
    step(1);
    chk("pz_paused", 32'(running), 32'd0);
    pause = 1'b0;
    step(10);
    chk("pz_hold5", 32'(count), 32'd5);
    pause = 1'b1;
    step(1);
    chk("pz_resumed", 32'(running), 32'd1);
    pause = 1'b0;
    step(1);
    chk("pz_resume1", 32'(count), 32'd5);
    step(1);
    chk("pz_resume2", 32'(count), 32'd4);

    // zero load goes straight to DONE; held start does not retrigger
    pause = 1'b1;
    step(1);
    pause    = 1'b0;
    load_val = 6'd0;
    start    = 1'b1;
    step(1);
    chk("zl_count", 32'(count), 32'd0);
    chk("zl_done", 32'(done), 32'd1);
    chk("zl_alarm", 32'(alarm), 32'd1);
    step(3);
    chk("zl_no_retrig", 32'(done), 32'd0);
    start = 1'b0;
    step(1);

    // pause coincident with a tick that leaves count nonzero
    load_val = 6'd2;
    start    = 1'b1;
    step(1);
    start = 1'b0;
    step(3);
    pause = 1'b1;
    step(1);
    chk("col1_count", 32'(count), 32'd1);
    chk("col1_paused", 32'(running), 32'd0);
    pause = 1'b0;
    step(3);
    chk("col1_hold", 32'(count), 32'd1);

    // start and pause edges together in PAUSE: start reloads
    load_val = 6'd1;
    start    = 1'b1;
    pause    = 1'b1;
    step(1);
    chk("both_reload", 32'(count), 32'd1);
    chk("both_running", 32'(running), 32'd1);
    start = 1'b0;
    pause = 1'b0;
    step(3);

    // pause coincident with the final tick: DONE wins, pause dropped
    pause = 1'b1;
    step(1);
    chk("col0_count", 32'(count), 32'd0);
    chk("col0_done", 32'(done), 32'd1);
    chk("col0_alarm", 32'(alarm), 32'd1);
    pause = 1'b0;
    step(1);
    pause = 1'b1;
    step(1);
    chk("col0_pause_ign", 32'(alarm), 32'd1);
    chk("col0_pause_run", 32'(running), 32'd0);
    pause = 1'b0;

    // reload from DONE, then reset mid-run
    load_val = 6'd7;
    start    = 1'b1;
    step(1);
    chk("rl_count", 32'(count), 32'd7);
    chk("rl_alarm", 32'(alarm), 32'd0);
    start = 1'b0;
    step(5);
    chk("rl_dec", 32'(count), 32'd6);
    reset = 1'b1;
    start = 1'b1;
    step(1);
    chk("mr_count", 32'(count), 32'd63);
    chk("mr_running", 32'(running), 32'd0);
    reset = 1'b0;
    start = 1'b0;
    step(1);

    // random button activity against the model
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 7) == 0) start = ~start;
      if ($urandom_range(0, 5) == 0) pause = ~pause;
      if ($urandom_range(0, 3) == 0) load_val = 6'($urandom_range(0, 63));
      else                           load_val = 6'($urandom_range(0, 4));
      step(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
